adder_station_param: RTL

ADDER_STATION_PARAM -- requirements
Module: adder_station_param

---
 rtl/adder_station_param_if.sv | 30 +++
 rtl/adder_station_param.sv | 113 +++++++++++
 2 files changed

// File: rtl/adder_station_param_if.sv
// adder_station_param_if: issue, CDB-snoop and FU-dispatch signals of the adder reservation station.
interface adder_station_param_if #(
    parameter int DATA_W  = 16,
    parameter int ENTRIES = 4,
    parameter int TAG_W   = 3,
    parameter int OP_W    = 4
);
    logic                         issue_valid, issue_ready;
    logic [OP_W-1:0]              issue_op;
    logic [DATA_W-1:0]            issue_vj, issue_vk;
    logic [TAG_W-1:0]             issue_qj, issue_qk, issue_tag;
    logic                         cdb_valid;
    logic [TAG_W-1:0]             cdb_tag;
    logic [DATA_W-1:0]            cdb_data;
    logic                         fu_valid, fu_ready;
    logic [OP_W-1:0]              fu_op;
    logic [DATA_W-1:0]            fu_a, fu_b;
    logic [TAG_W-1:0]             fu_tag;
    logic [$clog2(ENTRIES+1)-1:0] count;
    modport master (
        output issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
        output cdb_valid, cdb_tag, cdb_data, fu_ready,
        input  issue_ready, issue_tag, fu_valid, fu_op, fu_a, fu_b, fu_tag, count
    );
    modport slave (
        input  issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
        input  cdb_valid, cdb_tag, cdb_data, fu_ready,
        output issue_ready, issue_tag, fu_valid, fu_op, fu_a, fu_b, fu_tag, count
    );
endinterface

// File: rtl/adder_station_param.sv
// adder_station_param: reservation station with CDB snoop, issue bypass and oldest-ready-first dispatch.
module adder_station_param #(
    parameter int DATA_W   = 16,
    parameter int ENTRIES  = 4,
    parameter int TAG_W    = 3,
    parameter int BASE_TAG = 1,
    parameter int OP_W     = 4
) (
    input logic clk,
    input logic resetn,
    input logic flush,
    adder_station_param_if.slave bus
);
    localparam int IW = $clog2(ENTRIES);
    localparam int CW = $clog2(ENTRIES + 1);
    logic [ENTRIES-1:0] busy, rdy, sel;
    logic [ENTRIES-1:0] older [ENTRIES];
    logic [OP_W-1:0]    op [ENTRIES];
    logic [DATA_W-1:0]  vj [ENTRIES];
    logic [DATA_W-1:0]  vk [ENTRIES];
    logic [TAG_W-1:0]   qj [ENTRIES];
    logic [TAG_W-1:0]   qk [ENTRIES];
    logic [IW-1:0]      alloc_idx, sel_idx;
    logic [CW-1:0]      cnt;
    logic               any_free, cdb_hit, hit_j, hit_k, load, take, issue_ok;

    assign cdb_hit  = bus.cdb_valid && bus.cdb_tag != '0;
    assign hit_j    = cdb_hit && bus.issue_qj == bus.cdb_tag;
    assign hit_k    = cdb_hit && bus.issue_qk == bus.cdb_tag;
    assign load     = !bus.fu_valid || bus.fu_ready;
    assign take     = load && |rdy;
    assign issue_ok = bus.issue_valid && bus.issue_ready;

    assign bus.issue_ready = resetn && !flush && any_free;
    assign bus.issue_tag   = TAG_W'(BASE_TAG) + TAG_W'(alloc_idx);
    assign bus.count       = cnt;

    always_comb begin
        any_free  = 1'b0;
        alloc_idx = '0;
        cnt       = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                any_free  = 1'b1;
                alloc_idx = IW'(i);
            end
            cnt = cnt + CW'(busy[i]);
        end
    end

    always_comb begin
        rdy = '0;
        for (int i = 0; i < ENTRIES; i++)
            rdy[i] = busy[i] && qj[i] == '0 && qk[i] == '0;
    end

    // older[j][i] set means entry j was issued before entry i
    always_comb begin
        sel     = '0;
        sel_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            sel[i] = rdy[i];
            for (int j = 0; j < ENTRIES; j++)
                if (rdy[j] && older[j][i]) sel[i] = 1'b0;
            if (sel[i]) sel_idx = IW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            busy         <= '0;
            bus.fu_valid <= 1'b0;
            bus.fu_op    <= '0;
            bus.fu_a     <= '0;
            bus.fu_b     <= '0;
            bus.fu_tag   <= '0;
            for (int i = 0; i < ENTRIES; i++) older[i] <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (busy[i] && cdb_hit && qj[i] == bus.cdb_tag) begin
                    vj[i] <= bus.cdb_data;
                    qj[i] <= '0;
                end
                if (busy[i] && cdb_hit && qk[i] == bus.cdb_tag) begin
                    vk[i] <= bus.cdb_data;
                    qk[i] <= '0;
                end
                if (take && sel[i]) busy[i] <= 1'b0;
            end
            if (issue_ok) begin
                busy[alloc_idx] <= 1'b1;
                op[alloc_idx]   <= bus.issue_op;
                vj[alloc_idx]   <= hit_j ? bus.cdb_data : bus.issue_vj;
                vk[alloc_idx]   <= hit_k ? bus.cdb_data : bus.issue_vk;
                qj[alloc_idx]   <= hit_j ? '0 : bus.issue_qj;
                qk[alloc_idx]   <= hit_k ? '0 : bus.issue_qk;
                for (int j = 0; j < ENTRIES; j++) begin
                    older[alloc_idx][j] <= 1'b0;
                    older[j][alloc_idx] <= j != int'(alloc_idx);
                end
            end
            if (load) begin
                bus.fu_valid <= |rdy;
                if (|rdy) begin
                    bus.fu_op  <= op[sel_idx];
                    bus.fu_a   <= vj[sel_idx];
                    bus.fu_b   <= vk[sel_idx];
                    bus.fu_tag <= TAG_W'(BASE_TAG) + TAG_W'(sel_idx);
                end
            end
        end
    end
endmodule
